inst_dec_pipe: RTL and testbench

INST_DEC_PIPE -- requirements
Module: inst_dec_pipe

---
 rtl/inst_dec_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_inst_dec_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dec_pipe.sv
// RV32IM instruction decode stage: a small circular FIFO of {inst, pc} feeding a
// registered decode output with valid/ready handshakes on both sides.
module inst_dec_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_inst,
  input  logic [XLEN-1:0]            i_pc,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [XLEN-1:0]            o_pc,
  output logic [4:0]                 o_rd,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output logic [XLEN-1:0]            o_imm,
  output logic [2:0]                 o_funct3,
  output logic [2:0]                 o_op_mode,
  output logic [2:0]                 o_func_op,
  output logic                       o_alusrc,
  output logic                       o_mem_to_reg,
  output logic                       o_reg_write,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic                       o_branch,
  output logic                       o_jump,
  output logic                       o_unsigned,
  output logic [1:0]                 o_mem_size,
  output logic                       o_illegal,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [2:0]      op_mode;
    logic [2:0]      func_op;
    logic            alusrc;
    logic            mem_to_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            is_unsigned;
    logic [1:0]      mem_size;
    logic            illegal;
  } dec_t;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, out_free, fifo_empty, bypass, fifo_wr, fifo_rd;
  logic [31:0]     src_inst;
  logic [XLEN-1:0] src_pc;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            bad;
  dec_t            dec, out_q;

  assign o_ready    = !i_rst && (count < CW'(DEPTH));
  assign push       = i_valid && o_ready && !i_flush;
  assign out_free   = !o_valid || i_ready;
  assign fifo_empty = (count == '0);
  // An empty FIFO lets the incoming instruction skip straight into the output stage.
  assign bypass     = push && fifo_empty && out_free;
  assign fifo_wr    = push && !bypass;
  assign fifo_rd    = !fifo_empty && out_free;
  assign src_inst   = fifo_empty ? i_inst : inst_mem[rd_ptr];
  assign src_pc     = fifo_empty ? i_pc   : pc_mem[rd_ptr];

  assign imm_i = {{20{src_inst[31]}}, src_inst[31:20]};
  assign imm_s = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
  assign imm_b = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
  assign imm_u = {src_inst[31:12], 12'b0};
  assign imm_j = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.pc     = src_pc;
    dec.rd     = src_inst[11:7];
    dec.rs1    = src_inst[19:15];
    dec.rs2    = src_inst[24:20];
    dec.funct3 = src_inst[14:12];
    case (src_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.op_mode   = 3'd4;
        dec.imm       = XLEN'(imm_u);
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        if (src_inst[6:0] == OPC_LUI) dec.rs1 = 5'd0;
        else dec.func_op = 3'b100;
      end
      OPC_JAL, OPC_JALR: begin
        dec.op_mode   = 3'd4;
        dec.imm       = (src_inst[6:0] == OPC_JAL) ? XLEN'(imm_j) : XLEN'(imm_i);
        dec.jump      = 1'b1;
        dec.branch    = 1'b1;
        dec.reg_write = 1'b1;
        bad           = (src_inst[6:0] == OPC_JALR) && (src_inst[14:12] != 3'b000);
      end
      OPC_BRANCH: begin
        dec.op_mode     = 3'd3;
        dec.rd          = 5'd0;
        dec.imm         = XLEN'(imm_b);
        dec.branch      = 1'b1;
        dec.is_unsigned = src_inst[14] && src_inst[13];
        case (src_inst[14:12])
          3'b000:         dec.func_op = 3'b101;
          3'b001:         dec.func_op = 3'b100;
          3'b100, 3'b110: dec.func_op = 3'b000;
          3'b101, 3'b111: dec.func_op = 3'b011;
          default:        bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.op_mode     = 3'd4;
        dec.imm         = XLEN'(imm_i);
        dec.mem_read    = 1'b1;
        dec.mem_to_reg  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.mem_size    = src_inst[13:12];
        dec.is_unsigned = src_inst[14];
        bad = (src_inst[14:12] == 3'b011) || (src_inst[14:13] == 2'b11);
      end
      OPC_STORE: begin
        dec.op_mode   = 3'd4;
        dec.rd        = 5'd0;
        dec.imm       = XLEN'(imm_s);
        dec.mem_write = 1'b1;
        dec.mem_size  = src_inst[13:12];
        bad           = (src_inst[14:12] > 3'd2);
      end
      OPC_OPIMM: begin
        dec.imm       = XLEN'(imm_i);
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
        case (src_inst[14:12])
          3'b000: dec.op_mode = 3'd4;
          3'b010: dec.op_mode = 3'd3;
          3'b011: begin dec.op_mode = 3'd3; dec.is_unsigned = 1'b1; end
          3'b100: begin dec.op_mode = 3'd1; dec.func_op = 3'b010; end
          3'b110: begin dec.op_mode = 3'd1; dec.func_op = 3'b001; end
          3'b111: dec.op_mode = 3'd1;
          3'b001: begin
            dec.op_mode = 3'd2;
            bad = (src_inst[31:25] != 7'b0000000);
          end
          default: begin
            dec.op_mode = 3'd2;
            if (src_inst[31:25] == 7'b0000000)      dec.func_op = 3'b010;
            else if (src_inst[31:25] == 7'b0100000) dec.func_op = 3'b011;
            else                                    bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        case (src_inst[31:25])
          7'b0000000: begin
            case (src_inst[14:12])
              3'b000: dec.op_mode = 3'd4;
              3'b001: dec.op_mode = 3'd2;
              3'b010: dec.op_mode = 3'd3;
              3'b011: begin dec.op_mode = 3'd3; dec.is_unsigned = 1'b1; end
              3'b100: begin dec.op_mode = 3'd1; dec.func_op = 3'b010; end
              3'b101: begin dec.op_mode = 3'd2; dec.func_op = 3'b010; end
              3'b110: begin dec.op_mode = 3'd1; dec.func_op = 3'b001; end
              default: dec.op_mode = 3'd1;
            endcase
          end
          7'b0100000: begin
            if (src_inst[14:12] == 3'b000)      begin dec.op_mode = 3'd4; dec.func_op = 3'b001; end
            else if (src_inst[14:12] == 3'b101) begin dec.op_mode = 3'd2; dec.func_op = 3'b011; end
            else                                bad = 1'b1;
          end
          7'b0000001: begin
            if (!src_inst[14]) begin
              dec.op_mode = 3'd5;
              dec.func_op = {1'b0, src_inst[13:12]};
            end else begin
              dec.op_mode     = src_inst[13] ? 3'd7 : 3'd6;
              dec.is_unsigned = src_inst[12];
            end
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings keep only the PC and raw register/funct3 fields.
    if (bad) begin
      dec         = '0;
      dec.pc      = src_pc;
      dec.rs1     = src_inst[19:15];
      dec.rs2     = src_inst[24:20];
      dec.funct3  = src_inst[14:12];
      dec.illegal = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fifo_wr) begin
      inst_mem[wr_ptr] <= i_inst;
      pc_mem[wr_ptr]   <= i_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      out_q   <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
      if (fifo_rd || bypass) begin
        o_valid <= 1'b1;
        out_q   <= dec;
      end else if (out_free) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_count      = count;
  assign o_pc         = out_q.pc;
  assign o_rd         = out_q.rd;
  assign o_rs1        = out_q.rs1;
  assign o_rs2        = out_q.rs2;
  assign o_imm        = out_q.imm;
  assign o_funct3     = out_q.funct3;
  assign o_op_mode    = out_q.op_mode;
  assign o_func_op    = out_q.func_op;
  assign o_alusrc     = out_q.alusrc;
  assign o_mem_to_reg = out_q.mem_to_reg;
  assign o_reg_write  = out_q.reg_write;
  assign o_mem_read   = out_q.mem_read;
  assign o_mem_write  = out_q.mem_write;
  assign o_branch     = out_q.branch;
  assign o_jump       = out_q.jump;
  assign o_unsigned   = out_q.is_unsigned;
  assign o_mem_size   = out_q.mem_size;
  assign o_illegal    = out_q.illegal;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Directed bench for inst_dec_pipe: decode vectors, FIFO fill/drain, streaming,
// flush, mid-operation reset, and a 64-bit instance for immediate sign extension.
module tb_inst_dec_pipe;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_ready;
  logic [31:0] i_inst, i_pc;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3, o_op_mode, o_func_op;
  logic        o_alusrc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write;
  logic        o_branch, o_jump, o_unsigned, o_illegal;
  logic [1:0]  o_mem_size;
  logic [2:0]  o_count;

  logic        w_valid, w_ready, w_o_ready, w_o_valid;
  logic [31:0] w_inst;
  logic [63:0] w_pc, w_o_pc, w_o_imm;
  logic [4:0]  w_o_rd, w_o_rs1, w_o_rs2;
  logic [2:0]  w_o_funct3, w_o_op_mode, w_o_func_op;
  logic        w_o_alusrc, w_o_mem_to_reg, w_o_reg_write, w_o_mem_read, w_o_mem_write;
  logic        w_o_branch, w_o_jump, w_o_unsigned, w_o_illegal;
  logic [1:0]  w_o_mem_size;
  logic [2:0]  w_o_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  inst_dec_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
    .o_imm(o_imm), .o_funct3(o_funct3), .o_op_mode(o_op_mode), .o_func_op(o_func_op),
    .o_alusrc(o_alusrc), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
    .o_jump(o_jump), .o_unsigned(o_unsigned), .o_mem_size(o_mem_size),
    .o_illegal(o_illegal), .o_count(o_count)
  );

  inst_dec_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(w_valid), .o_ready(w_o_ready),
    .i_inst(w_inst), .i_pc(w_pc), .i_flush(1'b0), .o_valid(w_o_valid),
    .i_ready(w_ready), .o_pc(w_o_pc), .o_rd(w_o_rd), .o_rs1(w_o_rs1), .o_rs2(w_o_rs2),
    .o_imm(w_o_imm), .o_funct3(w_o_funct3), .o_op_mode(w_o_op_mode), .o_func_op(w_o_func_op),
    .o_alusrc(w_o_alusrc), .o_mem_to_reg(w_o_mem_to_reg), .o_reg_write(w_o_reg_write),
    .o_mem_read(w_o_mem_read), .o_mem_write(w_o_mem_write), .o_branch(w_o_branch),
    .o_jump(w_o_jump), .o_unsigned(w_o_unsigned), .o_mem_size(w_o_mem_size),
    .o_illegal(w_o_illegal), .o_count(w_o_count)
  );

  // ctrl packs {alusrc, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, unsigned, illegal}
  typedef struct {
    logic [31:0] inst;
    logic [2:0]  op;
    logic [2:0]  func;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [8:0]  ctrl;
    logic [1:0]  size;
    bit          chk_imm;
    bit          chk_func;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] pc);
    i_valid = 1'b1;
    i_inst  = inst;
    i_pc    = pc;
    tick();
    i_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] inst_v;
    logic [8:0]  ctrl_o;

    vecs.push_back('{32'hFFF00093, 3'd4, 3'd0, 5'd1, 32'hFFFFFFFF, 9'b101000000, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0200C0B3, 3'd6, 3'd0, 5'd1, 32'h0,        9'b001000000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000007F, 3'd0, 3'd0, 5'd0, 32'h0,        9'b000000001, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h123452B7, 3'd4, 3'd0, 5'd5, 32'h12345000, 9'b101000000, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h80000197, 3'd4, 3'd4, 5'd3, 32'h80000000, 9'b101000000, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h010000EF, 3'd4, 3'd0, 5'd1, 32'h00000010, 9'b001001100, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h000090E7, 3'd0, 3'd0, 5'd0, 32'h0,        9'b000000001, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0020E463, 3'd3, 3'd0, 5'd0, 32'h00000008, 9'b000001010, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h00209463, 3'd3, 3'd4, 5'd0, 32'h00000008, 9'b000001000, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0020A463, 3'd0, 3'd0, 5'd0, 32'h0,        9'b000000001, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFC14383, 3'd4, 3'd0, 5'd7, 32'hFFFFFFFC, 9'b011100010, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'hFE511F23, 3'd4, 3'd0, 5'd0, 32'hFFFFFFFE, 9'b000010000, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{32'h402081B3, 3'd4, 3'd1, 5'd3, 32'h0,        9'b001000000, 2'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h40325213, 3'd2, 3'd3, 5'd4, 32'h00000403, 9'b101000000, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h40321213, 3'd0, 3'd0, 5'd0, 32'h0,        9'b000000001, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h027332B3, 3'd5, 3'd3, 5'd5, 32'h0,        9'b001000000, 2'd0, 1'b0, 1'b1});
    vecs.push_back('{32'h023170B3, 3'd7, 3'd0, 5'd1, 32'h0,        9'b001000010, 2'd0, 1'b0, 1'b0});

    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_inst = '0; i_pc = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_inst = '0; w_pc = '0;
    tick();
    tick();
    check_output("rst.o_valid", 64'(o_valid), 64'd0);
    check_output("rst.o_count", 64'(o_count), 64'd0);
    check_output("rst.o_ready", 64'(o_ready), 64'd0);
    check_output("rst.o_imm", 64'(o_imm), 64'd0);
    check_output("rst.o_rd", 64'(o_rd), 64'd0);
    check_output("rst.o_reg_write", 64'(o_reg_write), 64'd0);
    i_rst = 1'b0;
    tick();
    check_output("post_rst.o_ready", 64'(o_ready), 64'd1);

    // Back-to-back decode through the bypass path with downstream always ready.
    i_ready = 1'b1;
    foreach (vecs[i]) begin
      inst_v = vecs[i].inst;
      apply_stimulus(inst_v, 32'h100 + 32'(4 * i));
      ctrl_o = {o_alusrc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write,
                o_branch, o_jump, o_unsigned, o_illegal};
      check_output($sformatf("v%0d.o_valid", i), 64'(o_valid), 64'd1);
      check_output($sformatf("v%0d.o_count", i), 64'(o_count), 64'd0);
      check_output($sformatf("v%0d.o_pc", i), 64'(o_pc), 64'(32'h100 + 32'(4 * i)));
      check_output($sformatf("v%0d.op_mode", i), 64'(o_op_mode), 64'(vecs[i].op));
      check_output($sformatf("v%0d.rd", i), 64'(o_rd), 64'(vecs[i].rd));
      check_output($sformatf("v%0d.ctrl", i), 64'(ctrl_o), 64'(vecs[i].ctrl));
      check_output($sformatf("v%0d.funct3", i), 64'(o_funct3), 64'(inst_v[14:12]));
      if (vecs[i].chk_func) check_output($sformatf("v%0d.func_op", i), 64'(o_func_op), 64'(vecs[i].func));
      if (vecs[i].chk_imm) check_output($sformatf("v%0d.imm", i), 64'(o_imm), 64'(vecs[i].imm));
      if (vecs[i].ctrl[5] || vecs[i].ctrl[4])
        check_output($sformatf("v%0d.mem_size", i), 64'(o_mem_size), 64'(vecs[i].size));
    end
    tick();
    check_output("dec_done.o_valid", 64'(o_valid), 64'd0);

    // Fill: one in the output stage plus DEPTH in the FIFO, then drain in order.
    i_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) apply_stimulus(addi(k), 32'h200 + 32'(4 * k));
    check_output("full.o_count", 64'(o_count), 64'(DEPTH));
    check_output("full.o_ready", 64'(o_ready), 64'd0);
    check_output("full.o_valid", 64'(o_valid), 64'd1);
    check_output("full.o_pc", 64'(o_pc), 64'h200);
    check_output("full.o_imm", 64'(o_imm), 64'd0);
    check_output("full_hold.o_pc", 64'(o_pc), 64'h200);
    i_ready = 1'b1; i_valid = 1'b1; i_inst = addi(99); i_pc = 32'h2FC;
    check_output("full_pop.o_ready", 64'(o_ready), 64'd0);
    tick();
    i_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      check_output($sformatf("drain%0d.o_pc", k), 64'(o_pc), 64'(32'h200 + 32'(4 * k)));
      check_output($sformatf("drain%0d.o_imm", k), 64'(o_imm), 64'(k));
      check_output($sformatf("drain%0d.o_count", k), 64'(o_count), 64'(DEPTH - k));
      tick();
    end
    check_output("drained.o_valid", 64'(o_valid), 64'd0);
    check_output("drained.o_count", 64'(o_count), 64'd0);

    // Streaming with simultaneous push and pop at occupancy 2.
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) apply_stimulus(addi(s + 20), 32'h300 + 32'(4 * s));
    check_output("stream_pre.o_count", 64'(o_count), 64'd2);
    i_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      i_valid = 1'b1; i_inst = addi(j + 23); i_pc = 32'h300 + 32'(4 * (j + 3));
      tick();
      check_output($sformatf("stream%0d.o_count", j), 64'(o_count), 64'd2);
      check_output($sformatf("stream%0d.o_pc", j), 64'(o_pc), 64'(32'h300 + 32'(4 * (j + 1))));
    end
    i_valid = 1'b0;
    for (int s = 10; s <= 12; s++) begin
      check_output($sformatf("stream_tail%0d.o_pc", s), 64'(o_pc), 64'(32'h300 + 32'(4 * s)));
      check_output($sformatf("stream_tail%0d.o_imm", s), 64'(o_imm), 64'(s + 20));
      tick();
    end
    check_output("stream_done.o_valid", 64'(o_valid), 64'd0);

    // Flush with three buffered entries and a same-cycle input.
    i_ready = 1'b0;
    for (int s = 0; s < 4; s++) apply_stimulus(addi(s + 40), 32'h400 + 32'(4 * s));
    check_output("flush_pre.o_count", 64'(o_count), 64'd3);
    i_flush = 1'b1; i_valid = 1'b1; i_inst = addi(77); i_pc = 32'h4F0;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    check_output("flush.o_valid", 64'(o_valid), 64'd0);
    check_output("flush.o_count", 64'(o_count), 64'd0);
    check_output("flush.o_ready", 64'(o_ready), 64'd1);
    tick();
    check_output("flush_drop.o_valid", 64'(o_valid), 64'd0);
    i_ready = 1'b1;
    apply_stimulus(addi(5), 32'h500);
    check_output("post_flush.o_valid", 64'(o_valid), 64'd1);
    check_output("post_flush.o_pc", 64'(o_pc), 64'h500);
    check_output("post_flush.o_imm", 64'(o_imm), 64'd5);
    tick();

    // Reset mid-operation overrides a concurrent flush and discards everything.
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) apply_stimulus(addi(s + 60), 32'h600 + 32'(4 * s));
    i_rst = 1'b1; i_flush = 1'b1;
    tick();
    check_output("mid_rst.o_valid", 64'(o_valid), 64'd0);
    check_output("mid_rst.o_count", 64'(o_count), 64'd0);
    check_output("mid_rst.o_ready", 64'(o_ready), 64'd0);
    check_output("mid_rst.o_op_mode", 64'(o_op_mode), 64'd0);
    check_output("mid_rst.o_imm", 64'(o_imm), 64'd0);
    i_rst = 1'b0; i_flush = 1'b0;
    tick();
    check_output("mid_rst_after.o_ready", 64'(o_ready), 64'd1);
    check_output("mid_rst_after.o_valid", 64'(o_valid), 64'd0);

    // 64-bit instance: BEQ x1,x2,-8.
    w_ready = 1'b1; w_valid = 1'b1; w_inst = 32'hFE208CE3; w_pc = 64'h1_0000_0040;
    tick();
    w_valid = 1'b0;
    check_output("x64.o_valid", 64'(w_o_valid), 64'd1);
    check_output("x64.o_imm", w_o_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check_output("x64.o_func_op", 64'(w_o_func_op), 64'd5);
    check_output("x64.o_branch", 64'(w_o_branch), 64'd1);
    check_output("x64.o_op_mode", 64'(w_o_op_mode), 64'd3);
    check_output("x64.o_rd", 64'(w_o_rd), 64'd0);
    check_output("x64.o_pc", w_o_pc, 64'h1_0000_0040);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
